// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation wrapper.
package rsa_pkg;
   localparam int OPW       = 1024;
   localparam int NUM_SLOTS = 5;

   localparam logic [31:0] CMD_READ    = 32'd0;
   localparam logic [31:0] CMD_COMPUTE = 32'd1;
   localparam logic [31:0] CMD_WRITE   = 32'd2;

   localparam logic [2:0] SLOT_MSG    = 3'd0;
   localparam logic [2:0] SLOT_EXP    = 3'd1;
   localparam logic [2:0] SLOT_N      = 3'd2;
   localparam logic [2:0] SLOT_RMODN  = 3'd3;
   localparam logic [2:0] SLOT_R2MODN = 3'd4;

   typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_COMPUTE, ST_TX, ST_DONE} state_t;
   typedef enum logic [1:0] {PH_MT, PH_SQ, PH_MUL, PH_FINAL} phase_t;

   // Index of the highest set bit; 0 when v is zero.
   function automatic logic [9:0] msb_idx(input logic [OPW-1:0] v);
      msb_idx = '0;
      for (int i = 0; i < OPW; i++)
         if (v[i]) msb_idx = 10'(i);
   endfunction
endpackage

// File: rtl/rsa_exp_wrapper_montgomery_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-1024 mod n.
// Operands are latched on start; done pulses 1025 cycles later.
module montgomery_mul
   import rsa_pkg::*;
(
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   input  logic [OPW-1:0] n,
   output logic           done,
   output logic [OPW-1:0] result
);
   logic [OPW+1:0] t, t_add, t_red;
   logic [OPW-1:0] a_sh, b_r, n_r;
   logic [10:0]    cnt;
   logic           busy;

   // t stays below 2n, so t + b + n < 4n fits in OPW+2 bits.
   always_comb begin
      t_add = t + (a_sh[0] ? {2'b00, b_r} : '0);
      t_red = t_add[0] ? t_add + {2'b00, n_r} : t_add;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         t      <= '0;
         a_sh   <= '0;
         b_r    <= '0;
         n_r    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            a_sh <= a;
            b_r  <= b;
            n_r  <= n;
            t    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
         end else if (busy) begin
            if (cnt == 11'd1024) begin
               result <= (t >= {2'b00, n_r}) ? OPW'(t - {2'b00, n_r}) : t[OPW-1:0];
               busy   <= 1'b0;
               done   <= 1'b1;
            end else begin
               t    <= t_red >> 1;
               a_sh <= a_sh >> 1;
               cnt  <= cnt + 11'd1;
            end
         end
      end
   end
endmodule

// File: rtl/rsa_exp_wrapper.sv
// Command FSM, operand file and square-and-multiply sequencer around one
// Montgomery multiplier. Optional: EXP_SKIP_LEADING_ZEROS_EN.
module rsa_exp_wrapper
   import rsa_pkg::*;
(
   input  logic           clk,
   input  logic           resetn,
   input  logic [31:0]    arm_to_fpga_cmd,
   input  logic           arm_to_fpga_cmd_valid,
   output logic           fpga_to_arm_done,
   input  logic           fpga_to_arm_done_read,
   input  logic           arm_to_fpga_data_valid,
   output logic           arm_to_fpga_data_ready,
   input  logic [OPW-1:0] arm_to_fpga_data,
   output logic           fpga_to_arm_data_valid,
   input  logic           fpga_to_arm_data_ready,
   output logic [OPW-1:0] fpga_to_arm_data,
   output logic [3:0]     leds
);
   state_t                        state;
   phase_t                        phase;
   logic [NUM_SLOTS-1:0][OPW-1:0] opnd;
   logic [2:0]                    idx;
   logic [9:0]                    bit_idx;
   logic [OPW-1:0]                acc, mt, res_q;
   logic                          mm_start, mm_done;
   logic [OPW-1:0]                mm_a, mm_b, mm_res, exp_v;

   assign exp_v = opnd[SLOT_EXP];

   always_comb begin
      mm_a = acc;
      mm_b = acc;
      case (phase)
         PH_MT: begin
            mm_a = opnd[SLOT_MSG];
            mm_b = opnd[SLOT_R2MODN];
         end
         PH_MUL:   mm_b = mt;
         PH_FINAL: mm_b = OPW'(1);
         default:  mm_b = acc;
      endcase
   end

   montgomery_mul u_mm (
      .clk    (clk),
      .resetn (resetn),
      .start  (mm_start),
      .a      (mm_a),
      .b      (mm_b),
      .n      (opnd[SLOT_N]),
      .done   (mm_done),
      .result (mm_res)
   );

   // mm_start is a registered pulse so each MM samples operands updated
   // on the cycle the previous MM finished.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         phase    <= PH_MT;
         opnd     <= '0;
         idx      <= '0;
         bit_idx  <= '0;
         acc      <= '0;
         mt       <= '0;
         res_q    <= '0;
         mm_start <= 1'b0;
      end else begin
         mm_start <= 1'b0;
         case (state)
            ST_IDLE: if (arm_to_fpga_cmd_valid) begin
               case (arm_to_fpga_cmd)
                  CMD_READ:    state <= ST_RX;
                  CMD_COMPUTE: begin
                     state    <= ST_COMPUTE;
                     idx      <= '0;
                     phase    <= PH_MT;
                     mm_start <= 1'b1;
                  end
                  CMD_WRITE:   state <= ST_TX;
                  default:     state <= ST_DONE;
               endcase
            end
            ST_RX: if (arm_to_fpga_data_valid) begin
               opnd[idx] <= arm_to_fpga_data;
               idx       <= (idx == SLOT_R2MODN) ? 3'd0 : idx + 3'd1;
               state     <= ST_DONE;
            end
            ST_COMPUTE: if (mm_done) begin
               case (phase)
                  PH_MT: begin
                     mt       <= mm_res;
                     acc      <= opnd[SLOT_RMODN];
                     mm_start <= 1'b1;
`ifdef EXP_SKIP_LEADING_ZEROS_EN
                     if (exp_v == '0) begin
                        phase <= PH_FINAL;
                     end else begin
                        bit_idx <= msb_idx(exp_v);
                        phase   <= PH_SQ;
                     end
`else
                     bit_idx <= 10'(OPW - 1);
                     phase   <= PH_SQ;
`endif
                  end
                  PH_SQ: begin
                     acc      <= mm_res;
                     mm_start <= 1'b1;
                     if (exp_v[bit_idx])     phase   <= PH_MUL;
                     else if (bit_idx == '0) phase   <= PH_FINAL;
                     else                    bit_idx <= bit_idx - 10'd1;
                  end
                  PH_MUL: begin
                     acc      <= mm_res;
                     mm_start <= 1'b1;
                     if (bit_idx == '0) begin
                        phase <= PH_FINAL;
                     end else begin
                        bit_idx <= bit_idx - 10'd1;
                        phase   <= PH_SQ;
                     end
                  end
                  default: begin
                     res_q <= mm_res;
                     state <= ST_DONE;
                  end
               endcase
            end
            ST_TX:   if (fpga_to_arm_data_ready) state <= ST_DONE;
            ST_DONE: if (fpga_to_arm_done_read)  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign arm_to_fpga_data_ready = (state == ST_RX);
   assign fpga_to_arm_data_valid = (state == ST_TX);
   assign fpga_to_arm_done       = (state == ST_DONE);
   assign fpga_to_arm_data       = res_q;
   assign leds = {state == ST_DONE, state == ST_TX, state == ST_COMPUTE, state == ST_RX};
endmodule

// File: tb/tb_rsa_exp_wrapper.sv
// Directed bench for rsa_exp_wrapper: small hand-worked modexps plus one
// full-width case checked against a plain %-based modular exponentiation.
module tb_rsa_exp_wrapper;
   localparam int W       = 1024;
   localparam int MAX_CYC = 3_400_000;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [31:0]   cmd = '0;
   logic          cmd_valid = 1'b0;
   logic          done;
   logic          done_read = 1'b0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [W-1:0]  din = '0;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic [W-1:0]  dout;
   logic [3:0]    leds;

   int tests = 0;
   int fails = 0;

   rsa_exp_wrapper dut (
      .clk                    (clk),
      .resetn                 (resetn),
      .arm_to_fpga_cmd        (cmd),
      .arm_to_fpga_cmd_valid  (cmd_valid),
      .fpga_to_arm_done       (done),
      .fpga_to_arm_done_read  (done_read),
      .arm_to_fpga_data_valid (din_valid),
      .arm_to_fpga_data_ready (din_ready),
      .arm_to_fpga_data       (din),
      .fpga_to_arm_data_valid (dout_valid),
      .fpga_to_arm_data_ready (dout_ready),
      .fpga_to_arm_data       (dout),
      .leds                   (leds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp_v);
      tests++;
      if (got !== exp_v) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h (low 256 bits)", tag, got[255:0], exp_v[255:0]);
      end
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int n = 0;
      while (!done && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, W'(done), W'(1));
   endtask

   task automatic send_cmd(input logic [31:0] c);
      @(negedge clk);
      cmd       = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic ack_done();
      done_read = 1'b1;
      @(negedge clk);
      done_read = 1'b0;
   endtask

   // Valid is raised two cycles ahead of the READ, so ready meets a waiting valid.
   task automatic load(input logic [W-1:0] v);
      din       = v;
      din_valid = 1'b1;
      repeat (2) @(negedge clk);
      send_cmd(32'd0);
      wait_done("rx_done", 10);
      din_valid = 1'b0;
      ack_done();
   endtask

   task automatic compute();
      send_cmd(32'd1);
      wait_done("compute_done", MAX_CYC);
      ack_done();
   endtask

   task automatic read_result(input string tag, input logic [W-1:0] exp_v);
      send_cmd(32'd2);
      chk("tx_valid", W'(dout_valid), W'(1));
      chk(tag, dout, exp_v);
      dout_ready = 1'b1;
      wait_done("tx_done", 10);
      dout_ready = 1'b0;
      ack_done();
   endtask

   function automatic logic [W-1:0] modmul(input logic [W-1:0] a, b, n);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      p = p % {{W{1'b0}}, n};
      return p[W-1:0];
   endfunction

   function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [15:0] e,
                                           input logic [W-1:0] n);
      logic [W-1:0] r = W'(1);
      for (int i = 15; i >= 0; i--) begin
         r = modmul(r, r, n);
         if (e[i]) r = modmul(r, m, n);
      end
      return r;
   endfunction

   initial begin
      logic [W-1:0]   big_n, big_m, big_r, big_r2;
      logic [2*W-1:0] r_wide;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_done", W'(done), W'(0));
      chk("rst_ready", W'(din_ready), W'(0));
      chk("rst_valid", W'(dout_valid), W'(0));
      chk("rst_data", dout, W'(0));
      chk("rst_leds", W'(leds), W'(0));
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_leds", W'(leds), W'(0));

      // Unknown command is a no-op straight to DONE; WRITE before COMPUTE gives 0
      send_cmd(32'd7);
      chk("nop_done", W'(done), W'(1));
      ack_done();
      read_result("write_before_compute", W'(0));

      // First load: watch RX decode and done holding until acknowledged
      din = W'(2);
      din_valid = 1'b1;
      repeat (2) @(negedge clk);
      send_cmd(32'd0);
      chk("rx_leds", W'(leds), W'(4'b0001));
      chk("rx_ready", W'(din_ready), W'(1));
      wait_done("rx_done", 10);
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("done_held", W'(done), W'(1));
      chk("done_leds", W'(leds), W'(4'b1000));
      ack_done();
      chk("done_cleared", W'(done), W'(0));
      load(W'(5));
      load(W'(13));
      load(W'(3));
      load(W'(9));

      send_cmd(32'd1);
      chk("compute_leds", W'(leds), W'(4'b0010));
      wait_done("compute_done", MAX_CYC);
      ack_done();
      read_result("2^5_mod_13", W'(6));

      // Edge exponents with the same n (COMPUTE rewinds idx to msg)
      load(W'(7)); load(W'(2)); compute();
      read_result("7^2_mod_13", W'(10));
      load(W'(0)); load(W'(3)); compute();
      read_result("0^3_mod_13", W'(0));
      load(W'(7)); load(W'(0)); compute();
      read_result("7^0_mod_13", W'(1));

      // Reset in the middle of a compute
      send_cmd(32'd1);
      repeat (3000) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("abort_done", W'(done), W'(0));
      chk("abort_valid", W'(dout_valid), W'(0));
      chk("abort_leds", W'(leds), W'(0));
      chk("abort_data", dout, W'(0));
      @(negedge clk);
      resetn = 1'b1;

      // Six READs: the sixth wraps into the msg slot (11 -> 2)
      load(W'(11)); load(W'(5)); load(W'(13)); load(W'(3)); load(W'(9)); load(W'(2));
      compute();
      read_result("wrap_2^5_mod_13", W'(6));

      // Full width: odd n with MSB set, msg < n
      for (int i = 0; i < W / 32; i++) begin
         big_n[i*32 +: 32] = $urandom;
         big_m[i*32 +: 32] = $urandom;
      end
      big_n[W-1] = 1'b1;
      big_n[0]   = 1'b1;
      big_m[W-1] = 1'b0;
      r_wide = {{(W-1){1'b0}}, 1'b1, {W{1'b0}}} % {{W{1'b0}}, big_n};
      big_r  = r_wide[W-1:0];
      big_r2 = modmul(big_r, big_r, big_n);
      load(big_m); load(W'(16'hCE7B)); load(big_n); load(big_r); load(big_r2);
      compute();
      read_result("full_width", modexp(big_m, 16'hCE7B, big_n));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
